// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake, stall hold, flush and load-use bubble insertion.
// One cycle of latency; a downstream stall or a pending load-use hazard drops in_ready.
module idex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int M_W         = 3,
  parameter int ALUOP_W     = 2,
  parameter int MEMREAD_BIT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WB_W-1:0]      WB,
  input  logic [M_W-1:0]       M,
  input  logic [ALUOP_W+1:0]   EX,
  input  logic [DATA_W-1:0]    NextAdress,
  input  logic [DATA_W-1:0]    OP1,
  input  logic [DATA_W-1:0]    OP2,
  input  logic [DATA_W-1:0]    SignExt,
  input  logic [REG_W-1:0]     RS,
  input  logic [REG_W-1:0]     RT,
  input  logic [REG_W-1:0]     RD,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WB_W-1:0]      O_WB,
  output logic [M_W-1:0]       O_M,
  output logic                 O_RegDst,
  output logic [ALUOP_W-1:0]   O_ALUop,
  output logic                 O_ALUsrc,
  output logic [DATA_W-1:0]    O_NextAdress,
  output logic [DATA_W-1:0]    O_OP1,
  output logic [DATA_W-1:0]    O_OP2,
  output logic [DATA_W-1:0]    O_SignExt,
  output logic [REG_W-1:0]     O_RS,
  output logic [REG_W-1:0]     O_RT,
  output logic [REG_W-1:0]     O_RD,
  output logic                 load_use,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                 r_vld;
  logic [WB_W-1:0]      r_wb;
  logic [M_W-1:0]       r_m;
  logic                 r_regdst;
  logic [ALUOP_W-1:0]   r_aluop;
  logic                 r_alusrc;
  logic [DATA_W-1:0]    r_na;
  logic [DATA_W-1:0]    r_op1;
  logic [DATA_W-1:0]    r_op2;
  logic [DATA_W-1:0]    r_se;
  logic [REG_W-1:0]     r_rs;
  logic [REG_W-1:0]     r_rt;
  logic [REG_W-1:0]     r_rd;
  logic [CNT_W-1:0]     r_bcnt;
  logic [CNT_W-1:0]     r_fcnt;

  logic w_hazard;
  logic w_stall;
  logic w_rs_match;
  logic w_rt_match;

  // $zero is never a real producer, so a held load targeting it cannot cause a hazard.
  assign w_rs_match = (RS == r_rt);
  assign w_rt_match = (RT == r_rt);
  assign w_hazard   = r_vld & r_m[MEMREAD_BIT] & (r_rt != '0) & in_valid & (w_rs_match | w_rt_match);
  assign w_stall    = r_vld & ~out_ready;

  assign load_use   = w_hazard;
  assign in_ready   = flush | (~w_hazard & ~w_stall);

  // Control fields are cleared whenever the stage goes invalid, so EX never sees stale enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= 1'b0;
      r_wb     <= '0;
      r_m      <= '0;
      r_regdst <= 1'b0;
      r_aluop  <= '0;
      r_alusrc <= 1'b0;
      r_na     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_se     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_bcnt   <= '0;
      r_fcnt   <= '0;
    end else if (flush) begin
      r_vld    <= 1'b0;
      r_wb     <= '0;
      r_m      <= '0;
      r_regdst <= 1'b0;
      r_aluop  <= '0;
      r_alusrc <= 1'b0;
      if (r_fcnt != CNT_MAX) r_fcnt <= r_fcnt + CNT_ONE;
    end else if (w_stall) begin
      r_vld <= r_vld;
    end else if (w_hazard) begin
      r_vld    <= 1'b0;
      r_wb     <= '0;
      r_m      <= '0;
      r_regdst <= 1'b0;
      r_aluop  <= '0;
      r_alusrc <= 1'b0;
      if (r_bcnt != CNT_MAX) r_bcnt <= r_bcnt + CNT_ONE;
    end else if (in_valid) begin
      r_vld    <= 1'b1;
      r_wb     <= WB;
      r_m      <= M;
      r_regdst <= EX[0];
      r_aluop  <= EX[ALUOP_W:1];
      r_alusrc <= EX[ALUOP_W+1];
      r_na     <= NextAdress;
      r_op1    <= OP1;
      r_op2    <= OP2;
      r_se     <= SignExt;
      r_rs     <= RS;
      r_rt     <= RT;
      r_rd     <= RD;
    end else begin
      r_vld    <= 1'b0;
      r_wb     <= '0;
      r_m      <= '0;
      r_regdst <= 1'b0;
      r_aluop  <= '0;
      r_alusrc <= 1'b0;
    end
  end

  assign out_valid    = r_vld;
  assign O_WB         = r_wb;
  assign O_M          = r_m;
  assign O_RegDst     = r_regdst;
  assign O_ALUop      = r_aluop;
  assign O_ALUsrc     = r_alusrc;
  assign O_NextAdress = r_na;
  assign O_OP1        = r_op1;
  assign O_OP2        = r_op2;
  assign O_SignExt    = r_se;
  assign O_RS         = r_rs;
  assign O_RT         = r_rt;
  assign O_RD         = r_rd;
  assign bubble_cnt   = r_bcnt;
  assign flush_cnt    = r_fcnt;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Randomised scoreboard bench for idex_pipe_reg with a behavioural model of the stage.
module tb_idex_pipe_reg;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] na, op1, op2, se;
    logic [4:0]  rs, rt, rd;
  } ins_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst;
    logic [1:0]  aluop;
    logic        alusrc;
    logic [31:0] na, op1, op2, se;
    logic [4:0]  rs, rt, rd;
    logic [15:0] bc, fc;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_ready, out_valid, load_use;
  logic [1:0]  WB, O_WB;
  logic [2:0]  M, O_M;
  logic [3:0]  EX;
  logic        O_RegDst, O_ALUsrc;
  logic [1:0]  O_ALUop;
  logic [31:0] NextAdress, OP1, OP2, SignExt;
  logic [31:0] O_NextAdress, O_OP1, O_OP2, O_SignExt;
  logic [4:0]  RS, RT, RD, O_RS, O_RT, O_RD;
  logic [15:0] bubble_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  snap_t mdl;
  snap_t exp_q[$];

  idex_pipe_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .WB(WB), .M(M), .EX(EX), .NextAdress(NextAdress), .OP1(OP1), .OP2(OP2),
    .SignExt(SignExt), .RS(RS), .RT(RT), .RD(RD), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .O_WB(O_WB), .O_M(O_M),
    .O_RegDst(O_RegDst), .O_ALUop(O_ALUop), .O_ALUsrc(O_ALUsrc),
    .O_NextAdress(O_NextAdress), .O_OP1(O_OP1), .O_OP2(O_OP2),
    .O_SignExt(O_SignExt), .O_RS(O_RS), .O_RT(O_RT), .O_RD(O_RD),
    .load_use(load_use), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s = '{v: out_valid, wb: O_WB, m: O_M, regdst: O_RegDst, aluop: O_ALUop,
          alusrc: O_ALUsrc, na: O_NextAdress, op1: O_OP1, op2: O_OP2,
          se: O_SignExt, rs: O_RS, rt: O_RT, rd: O_RD, bc: bubble_cnt, fc: flush_cnt};
    return s;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    x.wb  = 2'($urandom);
    x.m   = 3'($urandom);
    x.ex  = 4'($urandom);
    x.na  = $urandom;
    x.op1 = $urandom;
    x.op2 = $urandom;
    x.se  = $urandom;
    x.rs  = 5'($urandom_range(0, 3));
    x.rt  = 5'($urandom_range(0, 3));
    x.rd  = 5'($urandom_range(0, 31));
    return x;
  endfunction

  // The stage either holds one instruction or nothing; an empty stage shows no control.
  function automatic snap_t empty_stage(input snap_t s);
    snap_t r = s;
    r.v = 1'b0; r.wb = '0; r.m = '0; r.regdst = 1'b0; r.aluop = '0; r.alusrc = 1'b0;
    return r;
  endfunction

  task automatic drive(input logic iv, input ins_t x, input logic ordy, input logic fl);
    logic hz, rdy;
    @(negedge clk);
    in_valid = iv; WB = x.wb; M = x.m; EX = x.ex; NextAdress = x.na; OP1 = x.op1;
    OP2 = x.op2; SignExt = x.se; RS = x.rs; RT = x.rt; RD = x.rd;
    out_ready = ordy; flush = fl;
    #1;
    hz  = mdl.v && mdl.m[1] && (mdl.rt != 0) && iv && (x.rs == mdl.rt || x.rt == mdl.rt);
    rdy = fl || (!hz && (!mdl.v || ordy));
    chk("load_use", 192'(load_use), 192'(hz));
    chk("in_ready", 192'(in_ready), 192'(rdy));
    if (fl) begin
      mdl = empty_stage(mdl);
      if (mdl.fc != 16'hFFFF) mdl.fc = mdl.fc + 1;
    end else if (mdl.v && !ordy) begin
      mdl = mdl;
    end else if (hz) begin
      mdl = empty_stage(mdl);
      if (mdl.bc != 16'hFFFF) mdl.bc = mdl.bc + 1;
    end else if (iv) begin
      mdl.v = 1'b1; mdl.wb = x.wb; mdl.m = x.m; mdl.regdst = x.ex[0];
      mdl.aluop = x.ex[2:1]; mdl.alusrc = x.ex[3];
      mdl.na = x.na; mdl.op1 = x.op1; mdl.op2 = x.op2; mdl.se = x.se;
      mdl.rs = x.rs; mdl.rt = x.rt; mdl.rd = x.rd;
    end else begin
      mdl = empty_stage(mdl);
    end
    exp_q.push_back(mdl);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stage_snapshot", 192'(dut_snap()), 192'(e));
      end
    end
  end

  initial begin : stim
    ins_t x, lw, dep;
    reset = 1'b1; in_valid = 0; flush = 0; out_ready = 0;
    WB = 0; M = 0; EX = 0; NextAdress = 0; OP1 = 0; OP2 = 0; SignExt = 0; RS = 0; RT = 0; RD = 0;
    mdl = '0;
    #12;
    chk("reset_state", 192'(dut_snap()), 192'(0));
    chk("reset_in_ready", 192'(in_ready), 192'(1));
    @(negedge clk);
    reset = 1'b0;

    x = '0; x.ex = 4'b1011; x.op1 = 32'h1234; x.rd = 5'd5;
    drive(1, x, 1, 0);
    settle();
    chk("pass_valid", 192'(out_valid), 192'(1));
    chk("pass_ctrl", 192'({O_RegDst, O_ALUop, O_ALUsrc}), 192'(4'b1011));
    chk("pass_op1", 192'(O_OP1), 192'(32'h1234));
    chk("pass_rd", 192'(O_RD), 192'(5));

    for (int i = 0; i < 3; i++) begin
      x = rand_ins(); x.m = 3'b000;
      drive(1, x, 0, 0);
      chk("stall_in_ready", 192'(in_ready), 192'(0));
      settle();
      chk("stall_hold_op1", 192'(O_OP1), 192'(32'h1234));
    end
    x = '0; x.op1 = 32'h5678;
    drive(1, x, 1, 0);
    settle();
    chk("stall_release_op1", 192'(O_OP1), 192'(32'h5678));

    lw = '0; lw.m = 3'b010; lw.rt = 5'd8; lw.wb = 2'b11;
    dep = '0; dep.rs = 5'd8; dep.op1 = 32'hBEEF;
    drive(1, lw, 1, 0);
    drive(1, dep, 1, 0);
    chk("lu_load_use", 192'(load_use), 192'(1));
    chk("lu_in_ready", 192'(in_ready), 192'(0));
    settle();
    chk("lu_bubble", 192'({out_valid, O_M}), 192'(0));
    chk("lu_bubble_cnt", 192'(bubble_cnt), 192'(1));
    drive(1, dep, 1, 0);
    chk("lu_after_bubble", 192'(load_use), 192'(0));
    settle();
    chk("lu_dep_loaded", 192'({out_valid, O_RS}), 192'({1'b1, 5'd8}));

    x = '0; x.m = 3'b010; x.rt = 5'd0;
    drive(1, x, 1, 0);
    x = '0; x.rs = 5'd0;
    drive(1, x, 1, 0);
    chk("zero_reg_no_hazard", 192'(load_use), 192'(0));
    settle();
    chk("zero_reg_loaded", 192'(out_valid), 192'(1));

    drive(1, lw, 1, 0);
    drive(1, dep, 0, 1);
    chk("flush_hazard_seen", 192'(load_use), 192'(1));
    settle();
    chk("flush_cleared", 192'({out_valid, O_WB}), 192'(0));
    chk("flush_cnt_one", 192'(flush_cnt), 192'(1));
    chk("flush_bubble_same", 192'(bubble_cnt), 192'(1));

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, rand_ins(), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);

    x = rand_ins();
    drive(1, x, 1, 1);
    drive(1, x, 0, 0);
    drive(1, rand_ins(), 0, 0);
    @(posedge clk);
    #3;
    chk("pre_reset_valid", 192'(out_valid), 192'(1));
    reset = 1'b1;
    #1;
    chk("midstall_reset", 192'(dut_snap()), 192'(0));
    mdl = '0;
    in_valid = 0; flush = 0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 65540; i++)
      drive($urandom_range(0, 1), rand_ins(), $urandom_range(0, 1), 1);
    settle();
    chk("flush_cnt_saturated", 192'(flush_cnt), 192'(16'hFFFF));
    drive(1, rand_ins(), 1, 1);
    settle();
    chk("flush_cnt_stays_max", 192'(flush_cnt), 192'(16'hFFFF));
    chk("scoreboard_drained", 192'(exp_q.size()), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
Name: idex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register, the successor to the plain pass-through ID/EX latch.
- Adds a real clocked register stage with a valid/ready handshake, downstream stall hold and synchronous flush.
- Detects load-use hazards internally and inserts a single bubble for each one.
- Keeps saturating bubble and flush counters for performance debug.
- Sits between the decode stage and the EX stage of the MIPS pipeline.

Parameters:
- DATA_W, 32, width of NextAdress, OP1, OP2 and SignExt.
- REG_W, 5, register-address width of RS, RT and RD.
- WB_W, 2, write-back control field width.
- M_W, 3, memory control field width.
- ALUOP_W, 2, ALU-op width; the EX field is ALUOP_W+2 bits.
- MEMREAD_BIT, 1, index inside M that means MemRead.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents a valid instruction.
- in_ready  out  1  stage accepts the input this cycle (combinational).
- WB  in  WB_W  write-back controls.
- M  in  M_W  memory controls.
- EX  in  ALUOP_W+2  EX controls: bit0 RegDst, bits[ALUOP_W:1] ALUop, bit[ALUOP_W+1] ALUsrc.
- NextAdress  in  DATA_W  PC+4.
- OP1  in  DATA_W  register read data 1.
- OP2  in  DATA_W  register read data 2.
- SignExt  in  DATA_W  sign-extended immediate.
- RS  in  REG_W  source register index.
- RT  in  REG_W  source/target register index.
- RD  in  REG_W  destination register index.
- flush  in  1  squash the stage contents (branch taken or exception).
- out_ready  in  1  EX stage accepts the stage output.
- out_valid  out  1  stage holds a valid instruction.
- O_WB  out  WB_W  registered WB.
- O_M  out  M_W  registered M.
- O_RegDst  out  1  registered EX bit0.
- O_ALUop  out  ALUOP_W  registered EX ALUop bits.
- O_ALUsrc  out  1  registered EX top bit.
- O_NextAdress, O_OP1, O_OP2, O_SignExt  out  DATA_W each  registered data fields.
- O_RS, O_RT, O_RD  out  REG_W each  registered register indices.
- load_use  out  1  hazard indication to the PC and IF/ID stage (combinational).
- bubble_cnt  out  CNT_W  number of bubbles inserted.
- flush_cnt  out  CNT_W  number of flushes.

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every output register and both counters go to 0, so out_valid=0.
- hazard = out_valid & O_M[MEMREAD_BIT] & (O_RT!=0) & in_valid & ((RS==O_RT) | (RT==O_RT)).
- load_use = hazard.
- in_ready = flush | (~hazard & (~out_valid | out_ready)).
- Latency: 1 cycle. Each rising edge applies the first matching rule below.
  - 1. flush=1: out_valid<=0; O_WB, O_M, O_RegDst, O_ALUop, O_ALUsrc <=0; data and index fields hold; flush_cnt increments. The input handshake completes, but the input is discarded.
  - 2. out_valid & ~out_ready: hold all registers (downstream stall).
  - 3. hazard: load a bubble. out_valid<=0, control fields <=0, data fields hold, bubble_cnt increments. The input is not accepted, so upstream holds it.
  - 4. in_valid: load every input field; out_valid<=1.
  - 5. Otherwise: out_valid<=0 and control fields <=0.
- Control fields are always 0 whenever out_valid=0, so the EX stage can never see stale write or memory enables.
- A load-use pair produces exactly one bubble. After the bubble, out_valid=0, hazard deasserts, and the dependent instruction loads on the next edge.
- Hazard checking never matches O_RT=0 (register $zero).
- Counters saturate at 2^CNT_W-1 and do not wrap.
- flush together with a hazard: flush wins and bubble_cnt does not increment.
- flush together with a downstream stall: flush wins; the held instruction is discarded.

Test Plan:
- Reset: assert reset mid-cycle with out_valid=1 -> immediately out_valid=0, all O_* =0, both counters 0.
- Pass-through: in_valid=1, out_ready=1, EX=4'b1011, OP1=32'h1234, RD=5 -> next cycle out_valid=1, O_RegDst=1, O_ALUop=2'b01, O_ALUsrc=1, O_OP1=32'h1234, O_RD=5.
- Downstream stall: out_ready=0 for 3 cycles with new inputs presented -> outputs unchanged, in_ready=0 throughout; out_ready=1 -> next input loads.
- Load-use: lw with M=3'b010, RT=8 held in stage, next instruction RS=8 -> load_use=1, in_ready=0; one bubble inserted (out_valid=0, O_M=0), bubble_cnt=1; the dependent instruction loads on the following cycle.
- Zero register: held lw with RT=0 and next instruction RS=0 -> load_use=0, no bubble.
- Flush: flush=1 with hazard=1 and out_ready=0 -> next cycle out_valid=0, O_WB=0, flush_cnt=1, bubble_cnt unchanged; with flush_cnt preset to 16'hFFFF it stays 16'hFFFF.
